// File: rtl/rng_arbiter_if.sv
// Requester-side bus of rng_arbiter: requests, one-hot grant, captured random word.
// The RNG_ARB_STATS_EN macro adds grant_count and starve to the bundle.
interface rng_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = 13
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [WIDTH-1:0]   rnd_out;
  logic               rnd_valid;
  logic               busy;
`ifdef RNG_ARB_STATS_EN
  logic [7:0]         grant_count;
  logic [NUM_REQ-1:0] starve;
`endif

  // Arbiter side
  modport slave (
    input  req,
    output gnt, rnd_out, rnd_valid, busy
`ifdef RNG_ARB_STATS_EN
    , output grant_count, starve
`endif
  );

  // Requester side
  modport master (
    output req,
    input  gnt, rnd_out, rnd_valid, busy
`ifdef RNG_ARB_STATS_EN
    , input grant_count, starve
`endif
  );
endinterface

// File: rtl/rng_arbiter.sv
// Round-robin arbiter handing captured LFSR words to game-logic requesters,
// with a warm-up period after reset and a cooldown between grants.
// Optional statistics (grant_count, starve) are built when RNG_ARB_STATS_EN is defined.
module rng_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int WIDTH      = 13,
  parameter int MIN_SHIFTS = 13,
  parameter int WARMUP     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] rnd_in,
  rng_arbiter_if.slave     bus
);
  localparam int unsigned N       = NUM_REQ;
  localparam int          PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          CNT_MAX = (WARMUP > MIN_SHIFTS) ? WARMUP : MIN_SHIFTS;
  localparam int          CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  typedef enum logic [1:0] {
    S_WARMUP,
    S_READY,
    S_COOLDOWN
  } state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      win_idx;
  logic               win_found;
  logic               fire;
  logic [NUM_REQ-1:0] gnt_q;
  logic [WIDTH-1:0]   rnd_q;
  logic               valid_q;

  // Winner search: first requester after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      int unsigned idx;
      idx = (32'(rr_ptr) + k) % N;
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  // Next-state and cycle counter
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fire    = 1'b0;
    case (state)
      S_WARMUP: begin
        if (cnt == CW'(WARMUP - 1)) begin
          state_n = S_READY;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_READY: begin
        if (win_found) begin
          fire    = 1'b1;
          state_n = S_COOLDOWN;
          cnt_n   = '0;
        end
      end
      S_COOLDOWN: begin
        if (cnt == CW'(MIN_SHIFTS - 1)) begin
          state_n = S_READY;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = S_WARMUP;
        cnt_n   = '0;
      end
    endcase
  end

  // State register and grant pulse registration
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_WARMUP;
      cnt     <= '0;
      rr_ptr  <= PW'(NUM_REQ - 1);
      gnt_q   <= '0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      valid_q <= fire;
      gnt_q   <= fire ? (NUM_REQ'(1) << win_idx) : '0;
      if (fire) begin
        rnd_q  <= rnd_in;
        rr_ptr <= win_idx;
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rnd_out   = rnd_q;
  assign bus.rnd_valid = valid_q;
  assign bus.busy      = (state != S_READY);

`ifdef RNG_ARB_STATS_EN
  localparam int unsigned LIMIT = 4 * NUM_REQ * (MIN_SHIFTS + 1);
  localparam int          WW    = $clog2(LIMIT + 2);

  logic [7:0]         gcount;
  logic [NUM_REQ-1:0] starve_q;
  logic [WW-1:0]      wait_cnt [NUM_REQ];

  // Saturating grant count and per-requester wait tracking
  always_ff @(posedge clock) begin
    if (reset) begin
      gcount   <= '0;
      starve_q <= '0;
      for (int unsigned i = 0; i < N; i++) wait_cnt[i] <= '0;
    end else begin
      if (fire && gcount != '1) gcount <= gcount + 1'b1;
      for (int unsigned i = 0; i < N; i++) begin
        if (fire && 32'(win_idx) == i) begin
          wait_cnt[i] <= '0;
          starve_q[i] <= 1'b0;
        end else if (bus.req[i]) begin
          if (wait_cnt[i] != WW'(LIMIT + 1)) wait_cnt[i] <= wait_cnt[i] + 1'b1;
          if (wait_cnt[i] == WW'(LIMIT)) starve_q[i] <= 1'b1;
        end else begin
          wait_cnt[i] <= '0;
        end
      end
    end
  end

  assign bus.grant_count = gcount;
  assign bus.starve      = starve_q;
`endif
endmodule

// File: tb/tb_rng_arbiter.sv
// Self-checking bench for rng_arbiter: directed scenarios plus random traffic,
// compared every cycle against a timing/rotation model of the arbiter.
module tb_rng_arbiter;
  localparam int NUM_REQ    = 3;
  localparam int WIDTH      = 13;
  localparam int MIN_SHIFTS = 13;
  localparam int WARMUP     = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] rnd_in;

  rng_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  rng_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MIN_SHIFTS(MIN_SHIFTS), .WARMUP(WARMUP)
  ) dut (
    .clock (clock),
    .reset (reset),
    .rnd_in(rnd_in),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Model: edge index since reset, time of last grant, last winner
  int unsigned         e_now;
  bit                  have_grant;
  int unsigned         last_e;
  int unsigned         ptr;
  int unsigned         grants;
  logic [NUM_REQ-1:0]  exp_gnt;
  logic [WIDTH-1:0]    exp_rnd;
  logic                exp_valid;
  logic                exp_busy;

  function automatic bit eligible(int unsigned ee);
    if (have_grant) return (ee - last_e) >= MIN_SHIFTS + 1;
    return ee >= WARMUP + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int unsigned w;
    bit found;
    if (reset) begin
      e_now = 0; have_grant = 0; last_e = 0; ptr = NUM_REQ - 1; grants = 0;
      exp_gnt = '0; exp_valid = 1'b0; exp_rnd = '0;
    end else begin
      e_now++;
      exp_gnt = '0;
      exp_valid = 1'b0;
      if (eligible(e_now) && bus.req != '0) begin
        found = 0;
        w = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
          if (!found && bus.req[(ptr + k) % NUM_REQ]) begin
            found = 1;
            w = (ptr + k) % NUM_REQ;
          end
        end
        exp_gnt = NUM_REQ'(1) << w;
        exp_valid = 1'b1;
        exp_rnd = rnd_in;
        ptr = w;
        have_grant = 1;
        last_e = e_now;
        grants++;
      end
    end
    exp_busy = !eligible(e_now + 1);
  endtask

  // One clock: drive inputs, update model on the edge, compare on the falling edge
  task automatic tick(input logic r, input logic [NUM_REQ-1:0] q);
    reset   = r;
    bus.req = q;
    rnd_in  = WIDTH'($urandom);
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check("gnt", 32'(bus.gnt), 32'(exp_gnt));
    check("rnd_valid", 32'(bus.rnd_valid), 32'(exp_valid));
    check("rnd_out", 32'(bus.rnd_out), 32'(exp_rnd));
    check("busy", 32'(bus.busy), 32'(exp_busy));
`ifdef RNG_ARB_STATS_EN
    check("grant_count", 32'(bus.grant_count), (grants > 255) ? 32'd255 : 32'(grants));
    check("starve", 32'(bus.starve), 32'd0);
`endif
  endtask

  initial begin
    int n;
    bit seen;
    reset   = 1'b1;
    bus.req = '0;
    rnd_in  = '0;

    // Reset state
    tick(1'b1, '0);
    tick(1'b1, 3'b001);
    check("reset_busy", 32'(bus.busy), 32'd1);

    // First grant 17 edges after reset release
    n = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1'b0, 3'b001);
      n++;
      if (bus.gnt != '0) seen = 1;
    end
    check("first_grant_edge", 32'(n), 32'd17);
    check("first_grant_onehot", 32'(bus.gnt), 32'b001);
    tick(1'b0, '0);

    // All requesters held: rotation 1,2,0,... every 14 edges
    for (int i = 0; i < 4 * (MIN_SHIFTS + 1) + 2; i++) tick(1'b0, 3'b111);

    // Idle into READY, then grant requester 1
    for (int i = 0; i < 16; i++) tick(1'b0, '0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1'b0, 3'b010);
      if (bus.gnt != '0) seen = 1;
    end
    check("grant_req1", 32'(bus.gnt), 32'b010);

    // Short pulse from requester 2 during cooldown is dropped
    for (int i = 0; i < 5; i++) tick(1'b0, 3'b100);
    for (int i = 0; i < 20; i++) tick(1'b0, '0);
    check("pulse_ready_busy", 32'(bus.busy), 32'd0);

    // From rr_ptr=1 with req=011 the rotation wraps to requester 0
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1'b0, 3'b011);
      if (bus.gnt != '0) seen = 1;
    end
    check("wrap_to_req0", 32'(bus.gnt), 32'b001);
    tick(1'b0, '0);

    // Reset on the edge that would have granted
    for (int i = 0; i < 20; i++) tick(1'b0, '0);
    tick(1'b1, 3'b001);
    check("reset_abort_gnt", 32'(bus.gnt), 32'd0);
    check("reset_abort_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 20; i++) tick(1'b0, 3'b001);

`ifdef RNG_ARB_STATS_EN
    // Saturating grant counter and fairness under continuous re-requests
    for (int i = 0; i < 300 * (MIN_SHIFTS + 1); i++) tick(1'b0, 3'b101);
    check("grant_count_sat", 32'(bus.grant_count), 32'd255);
`endif

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++)
      tick(($urandom_range(0, 199) == 0), NUM_REQ'($urandom_range(0, 7)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
